game_tick_gen: RTL and testbench

Fast-domain consumer of the divided millisecond clock. It synchronizes and edge-detects the slow toggling tick, then derives game-rate timing from it: a programmable movement step pulse, a game-time seconds counter, and the power-pellet countdown with a warning/blink phase. It sits between the millisecond divider and the game logic (sprite movement, ghost mode control, HUD timer).

---
 rtl/game_tick_gen.sv | 168 ++++++++++++++++
 tb/tb_game_tick_gen.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_tick_gen.sv
// Fast-domain consumer of the divided 1 ms tick: synchronizes and edge-detects it,
// then derives the movement step pulse, game seconds and the power-pellet countdown.
module game_tick_gen #(
  parameter int POWER_MS = 8000,
  parameter int WARN_MS  = 2000,
  parameter int BLINK_MS = 250
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clk_1ms,
  input  logic        i_enable,
  input  logic [7:0]  i_move_period,
  input  logic        i_start_power,
  output logic        o_ms_pulse,
  output logic        o_step_pulse,
  output logic        o_second_pulse,
  output logic [15:0] o_seconds,
  output logic        o_power_active,
  output logic        o_power_warn,
  output logic        o_power_blink,
  output logic        o_power_done
);

  localparam logic [15:0] LP_POWER   = 16'(POWER_MS);
  localparam logic [15:0] LP_WARN    = 16'(WARN_MS);
  localparam logic [15:0] LP_BLINK   = 16'(BLINK_MS);
  localparam logic [9:0]  LP_MS_LAST = 10'd999;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_WARN} state_t;

  logic        r_s1, r_s2, r_s3;
  logic        r_ms_pulse;
  logic [7:0]  r_step_cnt;
  logic        r_step_pulse;
  logic [9:0]  r_ms_cnt;
  logic        r_second_pulse;
  logic [15:0] r_seconds;
  state_t      r_state;
  logic [15:0] r_remaining;
  logic [15:0] r_blink_cnt;
  logic        r_active, r_warn, r_blink, r_done;

  logic        w_tick;
  logic [7:0]  w_period;
  logic [8:0]  w_step_next;
  logic [15:0] w_rem_dec;
  logic [15:0] w_blink_next;

  // Game-rate logic only advances on ticks seen while the game is running.
  assign w_tick       = r_ms_pulse & i_enable;
  assign w_period     = (i_move_period == 8'd0) ? 8'd1 : i_move_period;
  assign w_step_next  = {1'b0, r_step_cnt} + 9'd1;
  assign w_rem_dec    = r_remaining - 16'd1;
  assign w_blink_next = r_blink_cnt + 16'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_s3       <= 1'b0;
      r_ms_pulse <= 1'b0;
    end else begin
      r_s1       <= i_clk_1ms;
      r_s2       <= r_s1;
      r_s3       <= r_s2;
      r_ms_pulse <= r_s2 & ~r_s3;
    end
  end

  // Compare against the live period so a lowered period fires on the very next tick.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_step_cnt   <= '0;
      r_step_pulse <= 1'b0;
    end else begin
      r_step_pulse <= 1'b0;
      if (w_tick) begin
        if (w_step_next >= {1'b0, w_period}) begin
          r_step_cnt   <= '0;
          r_step_pulse <= 1'b1;
        end else begin
          r_step_cnt <= w_step_next[7:0];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ms_cnt       <= '0;
      r_second_pulse <= 1'b0;
      r_seconds      <= '0;
    end else begin
      r_second_pulse <= 1'b0;
      if (w_tick) begin
        if (r_ms_cnt == LP_MS_LAST) begin
          r_ms_cnt       <= '0;
          r_second_pulse <= 1'b1;
          r_seconds      <= r_seconds + 16'd1;
        end else begin
          r_ms_cnt <= r_ms_cnt + 10'd1;
        end
      end
    end
  end

  // A (re)start wins over a coincident tick: the full duration is reloaded undecremented.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_blink_cnt <= '0;
      r_active    <= 1'b0;
      r_warn      <= 1'b0;
      r_blink     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start_power) begin
        r_state     <= S_ACTIVE;
        r_remaining <= LP_POWER;
        r_blink_cnt <= '0;
        r_active    <= 1'b1;
        r_warn      <= 1'b0;
        r_blink     <= 1'b0;
      end else if (w_tick && (r_state != S_IDLE)) begin
        r_remaining <= w_rem_dec;
        if (w_rem_dec == 16'd0) begin
          r_state  <= S_IDLE;
          r_done   <= 1'b1;
          r_active <= 1'b0;
          r_warn   <= 1'b0;
          r_blink  <= 1'b0;
        end else begin
          case (r_state)
            S_ACTIVE: begin
              if (w_rem_dec <= LP_WARN) begin
                r_state     <= S_WARN;
                r_warn      <= 1'b1;
                r_blink     <= 1'b1;
                r_blink_cnt <= '0;
              end
            end
            S_WARN: begin
              if (w_blink_next == LP_BLINK) begin
                r_blink     <= ~r_blink;
                r_blink_cnt <= '0;
              end else begin
                r_blink_cnt <= w_blink_next;
              end
            end
            default: r_state <= S_IDLE;
          endcase
        end
      end
    end
  end

  assign o_ms_pulse     = r_ms_pulse;
  assign o_step_pulse   = r_step_pulse;
  assign o_second_pulse = r_second_pulse;
  assign o_seconds      = r_seconds;
  assign o_power_active = r_active;
  assign o_power_warn   = r_warn;
  assign o_power_blink  = r_blink;
  assign o_power_done   = r_done;

endmodule

// File: tb/tb_game_tick_gen.sv
// Bench for game_tick_gen: a tick/countdown model compared every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_game_tick_gen;
  localparam int P_POWER = 10;
  localparam int P_WARN  = 4;
  localparam int P_BLINK = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_1ms = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  move_period = 8'd3;
  logic        start_power = 1'b0;
  logic        ms_pulse, step_pulse, second_pulse;
  logic [15:0] seconds;
  logic        power_active, power_warn, power_blink, power_done;

  int checks = 0;
  int failures = 0;

  game_tick_gen #(.POWER_MS(P_POWER), .WARN_MS(P_WARN), .BLINK_MS(P_BLINK)) dut (
    .i_clk(clk), .i_rst(rst), .i_clk_1ms(clk_1ms), .i_enable(enable),
    .i_move_period(move_period), .i_start_power(start_power),
    .o_ms_pulse(ms_pulse), .o_step_pulse(step_pulse), .o_second_pulse(second_pulse),
    .o_seconds(seconds), .o_power_active(power_active), .o_power_warn(power_warn),
    .o_power_blink(power_blink), .o_power_done(power_done)
  );

  always #5 clk = ~clk;

  // Model: ticks are counted, the countdown is a plain integer, blink is derived from
  // how many ticks have elapsed inside the warning window.
  int  q[$];
  int  cyc = 0;
  bit  prev_lvl = 0, exp_ms = 0, started = 0, m_tick = 0;
  int  scnt = 0, total = 0, sec_off = 0, rem = 0, wk = 0, eff = 1;
  bit  act = 0, e_step = 0, e_sec = 0, e_done = 0, e_warn = 0, e_blink = 0;
  logic [15:0] e_seconds;
  logic [22:0] exp_v, got_v;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      q.delete();
      prev_lvl = 0; exp_ms = 0; scnt = 0; total = 0; sec_off = 0;
      rem = 0; wk = 0; act = 0; e_step = 0; e_sec = 0; e_done = 0;
      started = 1;
    end else begin
      m_tick = exp_ms && enable;
      if (clk_1ms && !prev_lvl) q.push_back(cyc + 2);
      prev_lvl = clk_1ms;
      exp_ms = 0;
      if (q.size() > 0 && q[0] == cyc) begin
        exp_ms = 1;
        void'(q.pop_front());
      end
      e_step = 0; e_sec = 0; e_done = 0;
      if (m_tick) begin
        eff = (move_period == 0) ? 1 : int'(move_period);
        scnt++;
        if (scnt >= eff) begin scnt = 0; e_step = 1; end
        total++;
        if (total % 1000 == 0) e_sec = 1;
      end
      if (start_power) begin
        act = 1; rem = P_POWER; wk = 0;
      end else if (m_tick && act) begin
        rem--;
        if (rem == 0) begin act = 0; e_done = 1; end
        else if (rem + 1 <= P_WARN) wk++;
        else if (rem <= P_WARN) wk = 0;
      end
    end
    e_warn    = act && (rem <= P_WARN);
    e_blink   = e_warn && (((wk / P_BLINK) % 2) == 0);
    e_seconds = 16'((total / 1000 + sec_off) % 65536);
    if (started) begin
      exp_v = {exp_ms, e_step, e_sec, e_seconds, act, e_warn, e_blink, e_done};
      got_v = {ms_pulse, step_pulse, second_pulse, seconds, power_active, power_warn,
               power_blink, power_done};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL model_cycle %0d: got ms/step/sec=%b%b%b seconds=%0d act/warn/blink/done=%b%b%b%b expected %b%b%b seconds=%0d %b%b%b%b",
                 cyc, ms_pulse, step_pulse, second_pulse, seconds, power_active, power_warn,
                 power_blink, power_done, exp_ms, e_step, e_sec, e_seconds, act, e_warn,
                 e_blink, e_done);
      end
    end
  end

  // All stimulus waits go through nclk so clk_1ms has a single driver.
  bit run_1ms = 0;
  int div = 0;

  task automatic nclk();
    @(negedge clk);
    if (run_1ms) begin
      div++;
      if (div == 8) begin div = 0; clk_1ms = ~clk_1ms; end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_val);
    checks++;
    if (act_v !== exp_val) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act_v, exp_val);
    end
  endtask

  // Returns at the negedge where a tick pulse is present (not yet consumed).
  task automatic wait_pulse();
    int n = 0;
    nclk();
    while (!exp_ms && n < 64) begin nclk(); n++; end
    if (!exp_ms) begin
      checks++; failures++;
      $display("FAIL tick_timeout: got no tick expected tick within 64 cycles");
    end
  endtask

  task automatic tick();
    wait_pulse();
    nclk();
  endtask

  task automatic start_tick();
    wait_pulse();
    start_power = 1'b1;
    nclk();
    start_power = 1'b0;
  endtask

  initial begin
    int n, pc, done_at, sp_at, sp_cnt;
    logic [8:0] smask;
    logic [9:0] wv, bv, dv;

    repeat (3) nclk();
    rst = 1'b0;
    chk("reset_outputs", {ms_pulse, step_pulse, second_pulse, seconds, power_active,
        power_warn, power_blink, power_done}, 32'd0);

    // Tick latency and width; falling edge yields nothing.
    repeat (2) nclk();
    clk_1ms = 1'b1;
    n = 0;
    while (n < 10 && !ms_pulse) begin nclk(); n++; end
    chk("ms_latency", n, 3);
    nclk();
    chk("ms_width", ms_pulse, 0);
    repeat (4) nclk();
    clk_1ms = 1'b0;
    pc = 0;
    repeat (8) begin nclk(); pc += int'(ms_pulse); end
    chk("fall_no_pulse", pc, 0);

    // Step period 3, then 0 (every tick).
    run_1ms = 1;
    enable = 1'b1;
    move_period = 8'd3;
    for (int t = 1; t <= 9; t++) begin tick(); smask[t-1] = step_pulse; end
    chk("step_p3_mask", {23'd0, smask}, 32'b100100100);
    move_period = 8'd0;
    pc = 0;
    repeat (3) begin tick(); pc += int'(step_pulse); end
    chk("step_p0_count", pc, 3);

    // Power sequence from tick 0.
    start_tick();
    chk("power_active_rise", {power_active, power_warn, power_blink}, 32'b100);
    for (int t = 1; t <= 10; t++) begin
      tick();
      wv[t-1] = power_warn; bv[t-1] = power_blink; dv[t-1] = power_done;
    end
    chk("warn_pattern", {22'd0, wv}, 32'b0111100000);
    chk("blink_pattern", {22'd0, bv}, 32'b0001100000);
    chk("done_pattern", {22'd0, dv}, 32'b1000000000);
    nclk();
    chk("done_width", {power_done, power_active}, 0);

    // Restart while warning, coincident with a tick.
    start_tick();
    repeat (7) tick();
    chk("in_warn_tick7", {power_active, power_warn}, 32'b11);
    start_tick();
    chk("restart_state", {power_active, power_warn, power_blink}, 32'b100);
    done_at = 0;
    for (int t = 1; t <= 20 && done_at == 0; t++) begin tick(); if (power_done) done_at = t; end
    chk("restart_expiry", done_at, 10);

    // Pause for 5 ticks mid-power.
    start_tick();
    repeat (3) tick();
    enable = 1'b0;
    pc = 0;
    repeat (5) begin wait_pulse(); pc += int'(ms_pulse); nclk(); end
    chk("pause_ms_pulses", pc, 5);
    chk("pause_still_active", power_active, 1);
    enable = 1'b1;
    done_at = 0;
    for (int t = 1; t <= 20 && done_at == 0; t++) begin tick(); if (power_done) done_at = t; end
    chk("pause_expiry", done_at, 7);

    // Seconds: fresh reset, 1000 ticks, then force to 65535 and wrap.
    run_1ms = 0; clk_1ms = 1'b0; div = 0;
    rst = 1'b1;
    repeat (3) nclk();
    rst = 1'b0;
    chk("reset2_seconds", seconds, 0);
    run_1ms = 1;
    sp_at = 0; sp_cnt = 0;
    for (int t = 1; t <= 1000; t++) begin
      tick();
      if (second_pulse) begin sp_at = t; sp_cnt++; end
    end
    chk("second_pulse_tick", sp_at, 1000);
    chk("second_pulse_count", sp_cnt, 1);
    chk("seconds_one", seconds, 1);
    force dut.r_seconds = 16'hFFFF;
    sec_off = 65535 - total / 1000;
    nclk();
    release dut.r_seconds;
    chk("seconds_forced", seconds, 65535);
    sp_at = 0;
    for (int t = 1; t <= 1000; t++) begin tick(); if (second_pulse) sp_at = t; end
    chk("wrap_pulse_tick", sp_at, 1000);
    chk("seconds_wrap", seconds, 0);

    repeat (4) nclk();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
